// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: direction and boundary-policy encodings shared by the counter blocks
package updown_counter_pkg;
  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DOWN = 1'b1;
  localparam logic POL_WRAP = 1'b0;
  localparam logic POL_SAT = 1'b1;
endpackage

// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if: control and status bundle between a counter and its user
interface updown_counter_param_if #(parameter int WIDTH = 8);
  logic en;
  logic mode;
  logic sat;
  logic [WIDTH-1:0] step;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic clr_flags;
  logic [WIDTH-1:0] count;
  logic evt;
  logic ovf;
  logic unf;
  logic at_max;
  logic at_min;
  modport master (
    output en, mode, sat, step, load, load_val, clr_flags,
    input count, evt, ovf, unf, at_max, at_min
  );
  modport slave (
    input en, mode, sat, step, load, load_val, clr_flags,
    output count, evt, ovf, unf, at_max, at_min
  );
endinterface

// File: rtl/mod_step_alu.sv
// mod_step_alu: one modulo up/down step of count by s with wrap or saturate at the boundaries
module mod_step_alu
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  logic             mode,
  input  logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_hit,
  output logic             unf_hit
);
  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0] MAXX = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MODV = MAXX + (WIDTH+1)'(1);
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] wrap_up, wrap_dn;
  // both wrap results are below MAX_VAL+1, so truncation to WIDTH bits is exact
  assign sum = {1'b0, count} + {1'b0, s};
  assign wrap_up = WIDTH'(sum - MODV);
  assign wrap_dn = WIDTH'({1'b0, count} + MODV - {1'b0, s});
  assign ovf_hit = (mode == MODE_UP) && (sum > MAXX);
  assign unf_hit = (mode == MODE_DOWN) && (s > count);
  always_comb begin
    next_count = ovf_hit ? ((sat == POL_SAT) ? MAXW : wrap_up)
               : unf_hit ? ((sat == POL_SAT) ? '0 : wrap_dn)
               : (mode == MODE_UP) ? sum[WIDTH-1:0] : count - s;
  end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: modulo up/down counter with load, runtime step, wrap/saturate and sticky flags
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input logic clk,
  input logic rst,
  updown_counter_param_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_VAL);
  logic [WIDTH-1:0] cnt_q, s, lv, nxt;
  logic evt_q, ovf_q, unf_q, ovf_hit, unf_hit, stepping;
  assign s = (bus.step > MAXW) ? MAXW : bus.step;
  assign lv = (bus.load_val > MAXW) ? MAXW : bus.load_val;
  assign stepping = !bus.load && bus.en;
  mod_step_alu #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_alu (
    .count(cnt_q),
    .s(s),
    .mode(bus.mode),
    .sat(bus.sat),
    .next_count(nxt),
    .ovf_hit(ovf_hit),
    .unf_hit(unf_hit)
  );
  // a fresh boundary hit outranks clr_flags in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= bus.load ? lv : bus.en ? nxt : cnt_q;
      evt_q <= stepping && (ovf_hit || unf_hit);
      ovf_q <= (stepping && ovf_hit) || (ovf_q && !bus.clr_flags);
      unf_q <= (stepping && unf_hit) || (unf_q && !bus.clr_flags);
    end
  end
  assign bus.count = cnt_q;
  assign bus.evt = evt_q;
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
  assign bus.at_max = (cnt_q == MAXW);
  assign bus.at_min = (cnt_q == '0);
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed checks of updown_counter_param with WIDTH=8, MAX_VAL=9
module tb_updown_counter_param;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  updown_counter_param_if #(.WIDTH(8)) bus ();
  updown_counter_param #(.WIDTH(8), .MAX_VAL(9)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en = 0; bus.load = 0; bus.clr_flags = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); bus.load = 1; bus.load_val = 8'd5; tick();
    rst = 0; bus.load = 1; bus.load_val = 8'd5; bus.en = 1; bus.clr_flags = 0; tick();
    vectors++; if (bus.count !== 8'd0) begin miscompares++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    vectors++; if (bus.evt !== 1'b0) begin miscompares++; $display("FAIL rst_evt got=%b exp=0", bus.evt); end
    vectors++; if ({bus.ovf, bus.unf} !== 2'b00) begin miscompares++; $display("FAIL rst_flags got=%b exp=00", {bus.ovf, bus.unf}); end
    vectors++; if (bus.at_min !== 1'b1) begin miscompares++; $display("FAIL rst_at_min got=%b exp=1", bus.at_min); end
    rst = 1; idle();
  endtask

  task automatic test_up_wrap();
    bus.load = 1; bus.load_val = 8'd8; tick();
    idle(); bus.en = 1; bus.mode = 0; bus.step = 8'd1; bus.sat = 0; tick();
    vectors++; if (bus.count !== 8'd9) begin miscompares++; $display("FAIL upw_count9 got=%0d exp=9", bus.count); end
    vectors++; if (bus.at_max !== 1'b1 || bus.evt !== 1'b0) begin miscompares++; $display("FAIL upw_atmax got=%b%b exp=10", bus.at_max, bus.evt); end
    tick();
    vectors++; if (bus.count !== 8'd0) begin miscompares++; $display("FAIL upw_count0 got=%0d exp=0", bus.count); end
    vectors++; if (bus.evt !== 1'b1 || bus.ovf !== 1'b1) begin miscompares++; $display("FAIL upw_evt_ovf got=%b%b exp=11", bus.evt, bus.ovf); end
    idle(); tick();
    vectors++; if (bus.evt !== 1'b0 || bus.ovf !== 1'b1 || bus.count !== 8'd0) begin miscompares++; $display("FAIL upw_sticky got evt=%b ovf=%b cnt=%0d exp 0 1 0", bus.evt, bus.ovf, bus.count); end
  endtask

  task automatic test_down_wrap();
    bus.load = 1; bus.load_val = 8'd1; bus.clr_flags = 1; tick();
    vectors++; if (bus.count !== 8'd1 || bus.ovf !== 1'b0) begin miscompares++; $display("FAIL dnw_load got cnt=%0d ovf=%b exp 1 0", bus.count, bus.ovf); end
    idle(); bus.en = 1; bus.mode = 1; bus.step = 8'd3; bus.sat = 0; tick();
    vectors++; if (bus.count !== 8'd8) begin miscompares++; $display("FAIL dnw_count8 got=%0d exp=8", bus.count); end
    vectors++; if (bus.evt !== 1'b1 || bus.unf !== 1'b1) begin miscompares++; $display("FAIL dnw_evt_unf got=%b%b exp=11", bus.evt, bus.unf); end
    tick();
    vectors++; if (bus.count !== 8'd5 || bus.evt !== 1'b0) begin miscompares++; $display("FAIL dnw_count5 got cnt=%0d evt=%b exp 5 0", bus.count, bus.evt); end
  endtask

  task automatic test_saturate();
    idle(); bus.load = 1; bus.load_val = 8'd7; bus.clr_flags = 1; tick();
    idle(); bus.en = 1; bus.mode = 0; bus.step = 8'd5; bus.sat = 1; tick();
    vectors++; if (bus.count !== 8'd9 || bus.evt !== 1'b1 || bus.ovf !== 1'b1) begin miscompares++; $display("FAIL sat_up got cnt=%0d evt=%b ovf=%b exp 9 1 1", bus.count, bus.evt, bus.ovf); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (bus.count !== 8'd9 || bus.evt !== 1'b1) begin miscompares++; $display("FAIL sat_hold%0d got cnt=%0d evt=%b exp 9 1", i, bus.count, bus.evt); end
    end
    bus.mode = 1; bus.step = 8'd20; tick();
    vectors++; if (bus.count !== 8'd0 || bus.evt !== 1'b0 || bus.unf !== 1'b0) begin miscompares++; $display("FAIL sat_dn_exact got cnt=%0d evt=%b unf=%b exp 0 0 0", bus.count, bus.evt, bus.unf); end
    tick();
    vectors++; if (bus.count !== 8'd0 || bus.evt !== 1'b1 || bus.unf !== 1'b1) begin miscompares++; $display("FAIL sat_dn_hold got cnt=%0d evt=%b unf=%b exp 0 1 1", bus.count, bus.evt, bus.unf); end
  endtask

  task automatic test_load_priority();
    idle(); bus.load = 1; bus.en = 1; bus.load_val = 8'd12; bus.mode = 0; bus.step = 8'd1; bus.sat = 0; tick();
    vectors++; if (bus.count !== 8'd9 || bus.evt !== 1'b0) begin miscompares++; $display("FAIL ld_clamp got cnt=%0d evt=%b exp 9 0", bus.count, bus.evt); end
    bus.en = 0; bus.load_val = 8'd0; tick();
    idle(); bus.en = 1; bus.mode = 0; bus.step = 8'd200; bus.sat = 0; tick();
    vectors++; if (bus.count !== 8'd9 || bus.evt !== 1'b0) begin miscompares++; $display("FAIL step_clamp got cnt=%0d evt=%b exp 9 0", bus.count, bus.evt); end
    bus.step = 8'd0; tick();
    vectors++; if (bus.count !== 8'd9 || bus.evt !== 1'b0) begin miscompares++; $display("FAIL step_zero got cnt=%0d evt=%b exp 9 0", bus.count, bus.evt); end
  endtask

  task automatic test_flag_race();
    idle(); bus.clr_flags = 1; tick();
    vectors++; if ({bus.ovf, bus.unf} !== 2'b00 || bus.count !== 8'd9) begin miscompares++; $display("FAIL clr_only got flags=%b cnt=%0d exp 00 9", {bus.ovf, bus.unf}, bus.count); end
    bus.en = 1; bus.mode = 0; bus.step = 8'd1; bus.sat = 0; bus.clr_flags = 1; tick();
    vectors++; if (bus.ovf !== 1'b1 || bus.count !== 8'd0 || bus.evt !== 1'b1) begin miscompares++; $display("FAIL race_set got ovf=%b cnt=%0d evt=%b exp 1 0 1", bus.ovf, bus.count, bus.evt); end
    idle(); bus.clr_flags = 1; tick();
    vectors++; if (bus.ovf !== 1'b0 || bus.count !== 8'd0 || bus.evt !== 1'b0) begin miscompares++; $display("FAIL race_clr got ovf=%b cnt=%0d evt=%b exp 0 0 0", bus.ovf, bus.count, bus.evt); end
  endtask

  task automatic test_mid_reset();
    idle(); bus.load = 1; bus.load_val = 8'd9; tick();
    idle(); bus.en = 1; bus.mode = 0; bus.step = 8'd1; bus.sat = 0; rst = 0; tick();
    rst = 1; bus.en = 0; tick();
    vectors++; if (bus.count !== 8'd0 || bus.evt !== 1'b0 || bus.ovf !== 1'b0) begin miscompares++; $display("FAIL mid_rst got cnt=%0d evt=%b ovf=%b exp 0 0 0", bus.count, bus.evt, bus.ovf); end
  endtask

  initial begin
    rst = 0; bus.en = 0; bus.mode = 0; bus.sat = 0; bus.step = '0;
    bus.load = 0; bus.load_val = '0; bus.clr_flags = 0;
    tick();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_priority();
    test_flag_race();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
